hsdaoh_test_source: RTL and testbench

Test-data generator in the clk_data domain. It sits directly upstream of the async FIFO write port that feeds hsdaoh_core. It produces selectable 16-bit patterns at a programmable rate, paced by FIFO backpressure. It keeps sent and dropped word statistics so the host can check the HDMI capture path for gaps.

---
 rtl/hsdaoh_pkg.sv | 27 ++
 rtl/hsdaoh_pattern_gen.sv | 50 +++++
 rtl/hsdaoh_test_source.sv | 177 +++++++++++++++++
 tb/tb_hsdaoh_test_source.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsdaoh_pkg.sv
// Shared definitions for the hsdaoh test-data source.
// Contents:
//   - pattern mode encodings (MODE_*)
//   - generator state enum (state_t)
//   - 16-bit Fibonacci LFSR tap mask and its feedback helper
package hsdaoh_pkg;

    localparam logic [1:0] MODE_COUNTER = 2'd0;
    localparam logic [1:0] MODE_LFSR    = 2'd1;
    localparam logic [1:0] MODE_WALK    = 2'd2;
    localparam logic [1:0] MODE_CONST   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    // Taps 16,14,13,11 (polynomial x^16+x^14+x^13+x^11+1) as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Feedback bit shifted into bit 0: parity of the tapped bits.
    function automatic logic lfsr_feedback(input logic [15:0] value);
        return ^(value & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/hsdaoh_pattern_gen.sv
// Combinational pattern step and seed lookup for the test-data source.
// Ports:
//   mode         in  2      pattern select (MODE_*)
//   pattern      in  DSIZE  current pattern word
//   pattern_next out DSIZE  next(pattern) for the selected mode
//   seed         out DSIZE  start value for the selected mode
// The LFSR mode is defined on a 16-bit register, so DSIZE is expected to be 16.
module hsdaoh_pattern_gen
    import hsdaoh_pkg::*;
#(
    parameter int                DSIZE      = 16,
    parameter logic [DSIZE-1:0]  LFSR_SEED  = DSIZE'(16'hACE1),
    parameter logic [DSIZE-1:0]  CONST_WORD = DSIZE'(16'h5A5A)
) (
    input  logic [1:0]       mode,
    input  logic [DSIZE-1:0] pattern,
    output logic [DSIZE-1:0] pattern_next,
    output logic [DSIZE-1:0] seed
);

    // Per-mode next-state function and seed value.
    always_comb begin
        pattern_next = pattern;
        seed         = {DSIZE{1'b0}};
        case (mode)
            MODE_COUNTER: begin
                pattern_next = pattern + {{(DSIZE-1){1'b0}}, 1'b1};
                seed         = {DSIZE{1'b0}};
            end
            MODE_LFSR: begin
                pattern_next = {pattern[DSIZE-2:0], lfsr_feedback(pattern[15:0])};
                seed         = LFSR_SEED;
            end
            MODE_WALK: begin
                pattern_next = {pattern[DSIZE-2:0], pattern[DSIZE-1]};
                seed         = {{(DSIZE-1){1'b0}}, 1'b1};
            end
            MODE_CONST: begin
                // A switch into constant mode keeps whatever word is current.
                pattern_next = pattern;
                seed         = CONST_WORD;
            end
            default: begin
                pattern_next = pattern;
                seed         = {DSIZE{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/hsdaoh_test_source.sv
// Test-data generator feeding the async FIFO write port in front of hsdaoh_core.
// Emits a selectable pattern at a programmable rate, paced by FIFO backpressure,
// and keeps sent/dropped statistics for gap detection on the host.
// Ports:
//   clk_data      in   1      data clock (rising edge)
//   rst           in   1      synchronous reset, active-high
//   enable        in   1      asynchronous run request (synchronized internally)
//   mode          in   2      0 counter, 1 LFSR, 2 walking-one, 3 constant
//   rate_div      in   8      one word every rate_div+1 cycles
//   clear_stats   in   1      pulse: zero both statistics counters
//   fifo_full     in   1      FIFO wfull
//   fifo_awfull   in   1      FIFO almost-full
//   fifo_wdata    out  DSIZE  FIFO wdata
//   fifo_winc     out  1      FIFO write strobe
//   running       out  1      high in RUN and BACKOFF
//   words_sent    out  32     write strobes issued (wraps)
//   words_dropped out  16     ticks lost to a full FIFO (saturates)
module hsdaoh_test_source
    import hsdaoh_pkg::*;
#(
    parameter int                DSIZE        = 16,
    parameter bit                DROP_ON_FULL = 1'b0,
    parameter logic [DSIZE-1:0]  LFSR_SEED    = DSIZE'(16'hACE1),
    parameter logic [DSIZE-1:0]  CONST_WORD   = DSIZE'(16'h5A5A)
) (
    input  logic             clk_data,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [7:0]       rate_div,
    input  logic             clear_stats,
    input  logic             fifo_full,
    input  logic             fifo_awfull,
    output logic [DSIZE-1:0] fifo_wdata,
    output logic             fifo_winc,
    output logic             running,
    output logic [31:0]      words_sent,
    output logic [15:0]      words_dropped
);

    logic             enable_meta_r;
    logic             enable_sync_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       rate_cnt_r;
    logic [7:0]       rate_cnt_nxt_s;
    logic [DSIZE-1:0] pattern_r;
    logic [DSIZE-1:0] pattern_nxt_s;
    logic [DSIZE-1:0] gen_next_s;
    logic [DSIZE-1:0] gen_seed_s;
    logic             tick_s;
    logic             write_s;
    logic             drop_s;
    logic [DSIZE-1:0] fifo_wdata_r;
    logic             fifo_winc_r;
    logic             running_r;
    logic [31:0]      words_sent_r;
    logic [15:0]      words_dropped_r;

    hsdaoh_pattern_gen #(
        .DSIZE      (DSIZE),
        .LFSR_SEED  (LFSR_SEED),
        .CONST_WORD (CONST_WORD)
    ) u_pattern_gen (
        .mode         (mode),
        .pattern      (pattern_r),
        .pattern_next (gen_next_s),
        .seed         (gen_seed_s)
    );

    assign write_s = tick_s & ~fifo_full;
    assign drop_s  = tick_s & fifo_full;

    // Two-flop synchronizer for the board-pin enable.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            enable_meta_r <= 1'b0;
            enable_sync_r <= 1'b0;
        end else begin
            enable_meta_r <= enable;
            enable_sync_r <= enable_meta_r;
        end
    end

    // FSM state, rate counter and pattern registers.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rate_cnt_r <= 8'd0;
            pattern_r  <= {DSIZE{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            rate_cnt_r <= rate_cnt_nxt_s;
            pattern_r  <= pattern_nxt_s;
        end
    end

    // Next-state, tick generation, rate counter and pattern advance.
    always_comb begin
        state_nxt_s    = state_r;
        rate_cnt_nxt_s = rate_cnt_r;
        pattern_nxt_s  = pattern_r;
        tick_s         = 1'b0;
        if (!enable_sync_r) begin
            // Disable wins over everything; counter and pattern simply hold.
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s    = ST_RUN;
                    pattern_nxt_s  = gen_seed_s;
                    rate_cnt_nxt_s = 8'd0;
                end
                ST_RUN: begin
                    if ((DROP_ON_FULL == 1'b0) && fifo_awfull) begin
                        // Back off one cycle early so the registered strobe cannot overflow.
                        state_nxt_s = ST_BACKOFF;
                    end else if (rate_cnt_r == 8'd0) begin
                        tick_s         = 1'b1;
                        rate_cnt_nxt_s = rate_div;
                        if (!fifo_full || (DROP_ON_FULL == 1'b1)) begin
                            pattern_nxt_s = gen_next_s;
                        end else begin
                            pattern_nxt_s = pattern_r;
                        end
                    end else begin
                        rate_cnt_nxt_s = rate_cnt_r - 8'd1;
                    end
                end
                ST_BACKOFF: begin
                    if (!fifo_awfull) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_BACKOFF;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Registered FIFO write port, running flag and statistics.
    always_ff @(posedge clk_data) begin
        if (rst) begin
            fifo_wdata_r    <= {DSIZE{1'b0}};
            fifo_winc_r     <= 1'b0;
            running_r       <= 1'b0;
            words_sent_r    <= 32'd0;
            words_dropped_r <= 16'd0;
        end else begin
            fifo_winc_r <= write_s;
            running_r   <= (state_nxt_s != ST_IDLE);
            if (write_s) begin
                fifo_wdata_r <= pattern_r;
            end
            if (clear_stats) begin
                words_sent_r <= 32'd0;
            end else if (write_s) begin
                words_sent_r <= words_sent_r + 32'd1;
            end
            if (clear_stats) begin
                words_dropped_r <= 16'd0;
            end else if (drop_s && (words_dropped_r != 16'hFFFF)) begin
                words_dropped_r <= words_dropped_r + 16'd1;
            end
        end
    end

    assign fifo_wdata    = fifo_wdata_r;
    assign fifo_winc     = fifo_winc_r;
    assign running       = running_r;
    assign words_sent    = words_sent_r;
    assign words_dropped = words_dropped_r;

endmodule

// File: tb/tb_hsdaoh_test_source.sv
// Self-checking bench for hsdaoh_test_source: two instances (pause and drop
// variants) share stimulus; a behavioural model predicts every output each cycle.
module tb_hsdaoh_test_source;

    logic        clk_data = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  rate_div = 8'd0;
    logic        clear_stats = 1'b0;
    logic        fifo_full = 1'b0;
    logic        fifo_awfull = 1'b0;

    logic [15:0] wdata0, wdata1;
    logic        winc0, winc1, running0, running1;
    logic [31:0] sent0, sent1;
    logic [15:0] dropped0, dropped1;

    always #5 clk_data = ~clk_data;

    hsdaoh_test_source #(.DSIZE(16), .DROP_ON_FULL(1'b0)) dut0 (
        .clk_data(clk_data), .rst(rst), .enable(enable), .mode(mode),
        .rate_div(rate_div), .clear_stats(clear_stats), .fifo_full(fifo_full),
        .fifo_awfull(fifo_awfull), .fifo_wdata(wdata0), .fifo_winc(winc0),
        .running(running0), .words_sent(sent0), .words_dropped(dropped0));

    hsdaoh_test_source #(.DSIZE(16), .DROP_ON_FULL(1'b1)) dut1 (
        .clk_data(clk_data), .rst(rst), .enable(enable), .mode(mode),
        .rate_div(rate_div), .clear_stats(clear_stats), .fifo_full(fifo_full),
        .fifo_awfull(fifo_awfull), .fifo_wdata(wdata1), .fifo_winc(winc1),
        .running(running1), .words_sent(sent1), .words_dropped(dropped1));

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state, index 0 = pause variant, 1 = drop variant.
    bit          m_active [2];
    bit          m_paused [2];
    int          m_wait   [2];
    int          m_pat    [2];
    int          m_wdata  [2];
    bit          m_winc   [2];
    int unsigned m_sent   [2];
    int          m_dropped[2];
    bit          m_en1, m_en2;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pat_seed(input int md);
        case (md)
            0: return 0;
            1: return 'hACE1;
            2: return 1;
            default: return 'h5A5A;
        endcase
    endfunction

    function automatic int pat_next(input int p, input int md);
        int taps [4] = '{16, 14, 13, 11};
        int fb;
        case (md)
            0: return (p + 1) % 65536;
            1: begin
                fb = 0;
                for (int i = 0; i < 4; i++) fb = fb ^ ((p >> (taps[i] - 1)) & 1);
                return ((p * 2) % 65536) + fb;
            end
            2: return ((p * 2) % 65536) + (p / 32768);
            default: return p;
        endcase
    endfunction

    task automatic model_step();
        bit en_s;
        en_s = m_en2;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_active[k] = 0; m_paused[k] = 0; m_wait[k] = 0; m_pat[k] = 0;
                m_wdata[k] = 0; m_winc[k] = 0; m_sent[k] = 0; m_dropped[k] = 0;
            end else begin
                m_winc[k] = 0;
                if (!en_s) begin
                    m_active[k] = 0; m_paused[k] = 0;
                end else if (!m_active[k]) begin
                    m_active[k] = 1; m_paused[k] = 0; m_pat[k] = pat_seed(int'(mode)); m_wait[k] = 0;
                end else if (m_paused[k]) begin
                    if (!fifo_awfull) m_paused[k] = 0;
                end else if (k == 0 && fifo_awfull) begin
                    m_paused[k] = 1;
                end else if (m_wait[k] > 0) begin
                    m_wait[k] = m_wait[k] - 1;
                end else begin
                    m_wait[k] = int'(rate_div);
                    if (!fifo_full) begin
                        m_wdata[k] = m_pat[k]; m_winc[k] = 1;
                        m_pat[k] = pat_next(m_pat[k], int'(mode));
                        m_sent[k] = m_sent[k] + 1;
                    end else begin
                        if (m_dropped[k] < 65535) m_dropped[k] = m_dropped[k] + 1;
                        if (k == 1) m_pat[k] = pat_next(m_pat[k], int'(mode));
                    end
                end
                if (clear_stats) begin
                    m_sent[k] = 0; m_dropped[k] = 0;
                end
            end
        end
        if (rst) begin
            m_en1 = 0; m_en2 = 0;
        end else begin
            m_en2 = m_en1; m_en1 = enable;
        end
    endtask

    task automatic check_outputs();
        logic [65:0] exp;
        for (int k = 0; k < 2; k++) begin
            exp = {m_winc[k], m_active[k], 16'(m_wdata[k]), 32'(m_sent[k]), 16'(m_dropped[k])};
            if (k == 0) chk("cyc_dut0", {winc0, running0, wdata0, sent0, dropped0}, exp);
            else        chk("cyc_dut1", {winc1, running1, wdata1, sent1, dropped1}, exp);
        end
    endtask

    // One clock: model advances on the edge, DUT outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk_data);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; clear_stats = 1'b0; fifo_full = 1'b0; fifo_awfull = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  md;
        logic [7:0]  rd;
        logic [15:0] w0, w1, w2;
    } vec_t;

    vec_t vecs [5];
    int   got_idx [3];
    int   got_w   [3];
    int   n_got, cnt, s, r, got, got0;

    initial begin
        vecs[0] = '{md: 2'd0, rd: 8'd0, w0: 16'h0000, w1: 16'h0001, w2: 16'h0002};
        vecs[1] = '{md: 2'd0, rd: 8'd3, w0: 16'h0000, w1: 16'h0001, w2: 16'h0002};
        vecs[2] = '{md: 2'd1, rd: 8'd0, w0: 16'hACE1, w1: 16'h59C3, w2: 16'hB387};
        vecs[3] = '{md: 2'd2, rd: 8'd1, w0: 16'h0001, w1: 16'h0002, w2: 16'h0004};
        vecs[4] = '{md: 2'd3, rd: 8'd2, w0: 16'h5A5A, w1: 16'h5A5A, w2: 16'h5A5A};

        // Reset state (checked by the model compare inside cycle()).
        do_reset();
        chk("reset_outputs", {winc0, running0, wdata0, sent0, dropped0}, 66'd0);

        // Table: first three words, first-strobe latency and strobe spacing.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            mode = vecs[v].md; rate_div = vecs[v].rd; enable = 1'b1;
            n_got = 0;
            for (int i = 0; i < 3; i++) begin got_idx[i] = -1; got_w[i] = -1; end
            for (int c = 1; c <= 60; c++) begin
                cycle();
                if (winc0 && n_got < 3) begin
                    got_idx[n_got] = c; got_w[n_got] = int'(wdata0); n_got++;
                end
            end
            chk($sformatf("vec%0d_first_at", v), 66'(got_idx[0]), 66'(4));
            chk($sformatf("vec%0d_w0", v), 66'(got_w[0]), 66'(vecs[v].w0));
            chk($sformatf("vec%0d_w1", v), 66'(got_w[1]), 66'(vecs[v].w1));
            chk($sformatf("vec%0d_w2", v), 66'(got_w[2]), 66'(vecs[v].w2));
            chk($sformatf("vec%0d_gap1", v), 66'(got_idx[1] - got_idx[0]), 66'(int'(vecs[v].rd) + 1));
            chk($sformatf("vec%0d_gap2", v), 66'(got_idx[2] - got_idx[1]), 66'(int'(vecs[v].rd) + 1));
        end

        // 100 counter strobes, then almost-full backoff for 10 cycles.
        do_reset();
        mode = 2'd0; rate_div = 8'd0; enable = 1'b1; cnt = 0;
        for (int c = 0; c < 200 && cnt < 100; c++) begin
            cycle();
            if (winc0) cnt++;
        end
        chk("sent_100", 66'(sent0), 66'(100));
        chk("last_99", 66'(wdata0), 66'(99));
        fifo_awfull = 1'b1; s = 0; r = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            s += int'(winc0); r += int'(running0);
        end
        fifo_awfull = 1'b0;
        chk("awfull_no_strobe", 66'(s), 66'(0));
        chk("awfull_running", 66'(r), 66'(10));
        got = -1;
        for (int c = 0; c < 6 && got < 0; c++) begin
            cycle();
            if (winc0) got = int'(wdata0);
        end
        chk("awfull_resume", 66'(got), 66'(100));
        chk("awfull_dropped", 66'(dropped0), 66'(0));

        // Full for 5 ticks: drop variant skips ahead, pause variant holds.
        do_reset();
        enable = 1'b1; cnt = 0;
        for (int c = 0; c < 100 && cnt < 20; c++) begin
            cycle();
            if (winc1) cnt++;
        end
        chk("pre_full_last", 66'(wdata1), 66'(19));
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        fifo_full = 1'b0;
        got = -1; got0 = -1;
        for (int c = 0; c < 6 && got < 0; c++) begin
            cycle();
            if (winc1) got = int'(wdata1);
            if (winc0 && got0 < 0) got0 = int'(wdata0);
        end
        chk("drop_jump", 66'(got), 66'(25));
        chk("drop_count1", 66'(dropped1), 66'(5));
        chk("hold_value0", 66'(got0), 66'(20));
        chk("drop_count0", 66'(dropped0), 66'(5));

        // Enable low mid-burst, then re-enable restarts the counter.
        enable = 1'b0; s = 0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            if (i >= 2) s += int'(winc0);
        end
        chk("trail_strobes", 66'(s <= 1), 66'(1));
        chk("idle_in_3", 66'(running0), 66'(0));
        enable = 1'b1; got = -1;
        for (int c = 0; c < 10 && got < 0; c++) begin
            cycle();
            if (winc0) got = int'(wdata0);
        end
        chk("restart_zero", 66'(got), 66'(0));

        // clear_stats coincident with a strobe.
        clear_stats = 1'b1;
        cycle();
        clear_stats = 1'b0;
        chk("clr_coincide", 66'({winc0, sent0}), 66'({1'b1, 32'd0}));
        cycle();
        chk("clr_after", 66'(sent0), 66'(1));

        // Reset mid-run clears everything on that edge.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid0", {winc0, running0, wdata0, sent0, dropped0}, 66'd0);
        chk("rst_mid1", {winc1, running1, wdata1, sent1, dropped1}, 66'd0);

        // Randomized traffic against the model.
        enable = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) rate_div = 8'($urandom_range(0, 3));
            clear_stats = ($urandom_range(0, 29) == 0);
            fifo_full   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) fifo_awfull = ~fifo_awfull;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
